// File: rtl/st7735.sv
// ST7735 128x160 TFT init-and-fill controller.
// Pulses the panel reset, plays the power-up command list over a write-only
// 4-wire SPI link (mode 0, MSB first), streams one frame of a constant
// RGB565 colour, then idles with CS high until the next SYS_RST.
module st7735 #(
   parameter int unsigned CLK_DIV           = 1,
   parameter int unsigned RESET_LOW_CYCLES  = 120,
   parameter int unsigned POST_RESET_CYCLES = 1_440_000,
   parameter int unsigned SWRESET_DELAY     = 1_800_000,
   parameter int unsigned SLPOUT_DELAY      = 6_000_000,
   parameter int unsigned WIDTH             = 128,
   parameter int unsigned HEIGHT            = 160,
   parameter logic [15:0] FILL_COLOR        = 16'hF800
) (
   input  logic SYSTEM_CLK,
   input  logic SYS_RST,
   output logic CS,
   output logic MOSI,
   output logic DC,
   output logic LCD_CLK,
   output logic RESET
);

   localparam int unsigned NPIX  = WIDTH * HEIGHT;
   localparam int unsigned PIX_W = $clog2(NPIX + 1);
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNT_W = 32;
   localparam logic [4:0]  LAST_CMD = 5'd17;

   typedef enum logic [2:0] {
      RST_LOW, RST_WAIT, LOAD, SEND, GAP, DELAY, DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [DIV_W-1:0]   div_cnt;
   logic [2:0]         bit_cnt;
   logic [7:0]         shreg;
   logic [4:0]         idx;
   logic               pix_phase;
   logic               pix_lo;
   logic [PIX_W-1:0]   pix_cnt;
   // Active-high shadows of the active-low pins: an all-zero register
   // state then means "chip deselected, panel out of reset".
   logic               cs_on;
   logic               rst_on;
   logic               sclk;
   logic               mosi_r;
   logic               dc_r;

   logic               cur_dc;
   logic [7:0]         cur_byte;
   logic               need_delay;
   logic               frame_done;
   logic               start_byte;
   logic [CNT_W-1:0]   delay_lim;

   assign CS      = !cs_on;
   assign RESET   = !rst_on;
   assign LCD_CLK = sclk;
   assign MOSI    = mosi_r;
   assign DC      = dc_r;

   // Byte source: command ROM during init, fill colour halves during the frame
   always_comb begin
      cur_dc   = 1'b1;
      cur_byte = 8'h00;
      if (pix_phase) begin
         cur_byte = pix_lo ? FILL_COLOR[7:0] : FILL_COLOR[15:8];
      end else begin
         case (idx)
            5'd0:    begin cur_dc = 1'b0; cur_byte = 8'h01; end
            5'd1:    begin cur_dc = 1'b0; cur_byte = 8'h11; end
            5'd2:    begin cur_dc = 1'b0; cur_byte = 8'h3A; end
            5'd3:    cur_byte = 8'h05;
            5'd4:    begin cur_dc = 1'b0; cur_byte = 8'h36; end
            5'd6:    begin cur_dc = 1'b0; cur_byte = 8'h2A; end
            5'd10:   cur_byte = 8'(WIDTH - 1);
            5'd11:   begin cur_dc = 1'b0; cur_byte = 8'h2B; end
            5'd15:   cur_byte = 8'(HEIGHT - 1);
            5'd16:   begin cur_dc = 1'b0; cur_byte = 8'h29; end
            5'd17:   begin cur_dc = 1'b0; cur_byte = 8'h2C; end
            default: cur_byte = 8'h00;
         endcase
      end
   end

   // Sequencing decisions taken in the gap cycle (idx already points past the sent byte)
   always_comb begin
      need_delay = !pix_phase && (idx == 5'd1 || idx == 5'd2);
      frame_done = pix_phase && (pix_cnt == PIX_W'(NPIX));
      start_byte = (state == LOAD) || (state == GAP && !need_delay && !frame_done);
      delay_lim  = (idx == 5'd1) ? CNT_W'(SWRESET_DELAY) : CNT_W'(SLPOUT_DELAY);
   end

   // Main sequencer: reset pulse, waits, SPI byte shifter and frame counter
   always_ff @(posedge SYSTEM_CLK) begin
      if (SYS_RST) begin
         state     <= RST_LOW;
         cnt       <= '0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         idx       <= '0;
         pix_phase <= 1'b0;
         pix_lo    <= 1'b0;
         pix_cnt   <= '0;
         cs_on     <= 1'b0;
         rst_on    <= 1'b0;
         sclk      <= 1'b0;
         mosi_r    <= 1'b0;
         dc_r      <= 1'b0;
      end else begin
         case (state)
            RST_LOW: begin
               if (cnt == CNT_W'(RESET_LOW_CYCLES)) begin
                  rst_on <= 1'b0;
                  cnt    <= '0;
                  state  <= RST_WAIT;
               end else begin
                  rst_on <= 1'b1;
                  cnt    <= cnt + CNT_W'(1);
               end
            end
            // The rising edge of RESET counts as the first waiting cycle and
            // LOAD as the last, so CS falls exactly POST_RESET_CYCLES later.
            RST_WAIT: begin
               if (cnt + CNT_W'(2) >= CNT_W'(POST_RESET_CYCLES)) begin
                  cnt   <= '0;
                  state <= LOAD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SEND: begin
               if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                  div_cnt <= '0;
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else begin
                     sclk <= 1'b0;
                     if (bit_cnt == 3'd7) begin
                        cs_on  <= 1'b0;
                        mosi_r <= 1'b0;
                        state  <= GAP;
                        if (pix_phase) begin
                           pix_lo <= !pix_lo;
                           if (pix_lo) pix_cnt <= pix_cnt + PIX_W'(1);
                        end else if (idx == LAST_CMD) begin
                           pix_phase <= 1'b1;
                           pix_lo    <= 1'b0;
                           pix_cnt   <= '0;
                        end else begin
                           idx <= idx + 5'd1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                        mosi_r  <= shreg[6];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            GAP: begin
               if (need_delay) begin
                  cnt   <= '0;
                  state <= DELAY;
               end else if (frame_done) begin
                  state <= DONE;
               end
            end
            // Delay starts the cycle after the gap; LOAD is its last cycle.
            DELAY: begin
               if (cnt + CNT_W'(2) >= delay_lim) begin
                  cnt   <= '0;
                  state <= LOAD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               cs_on <= 1'b0;
               sclk  <= 1'b0;
            end
            default: ;
         endcase

         if (start_byte) begin
            cs_on   <= 1'b1;
            dc_r    <= cur_dc;
            mosi_r  <= cur_byte[7];
            shreg   <= cur_byte;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            state   <= SEND;
         end
      end
   end

endmodule

// File: tb/tb_st7735.sv
// Testbench for st7735: decodes the SPI stream and checks it against an
// expected byte table, plus reset, abort-and-restart and default-parameter runs.
module tb_st7735;

   localparam int unsigned T_RLC  = 4;
   localparam int unsigned T_PRC  = 8;
   localparam int unsigned T_SW   = 8;
   localparam int unsigned T_SLP  = 8;
   localparam int unsigned T_W    = 2;
   localparam int unsigned T_H    = 2;
   localparam logic [15:0] T_FILL = 16'hA55A;
   localparam int          NBYTES = 18 + 2 * T_W * T_H;
   localparam int          FIRST_CS = T_RLC + T_PRC + 1;

   logic clk;
   logic rst;
   logic cs, mosi, dc, sclk, lcd_rst;
   logic cs_d, mosi_d, dc_d, sclk_d, lcd_rst_d;
   logic rst_d;

   int n_cmp;
   int n_err;
   bit def_done;

   typedef struct {
      logic       dc;
      logic [7:0] data;
      int         gap;
   } rec_t;

   typedef struct packed {
      logic       dc;
      logic [7:0] data;
   } rx_t;

   rec_t tbl [NBYTES];
   int   n_tbl;

   rx_t  rx_q[$];
   int   gap_q[$];
   int   frame_bad;
   int   dc_bad;

   logic       prev_cs;
   logic       prev_sck;
   logic [7:0] shift;
   int         bits;
   logic       frame_dc;
   int         gap_cnt;

   st7735 #(
      .CLK_DIV(1), .RESET_LOW_CYCLES(T_RLC), .POST_RESET_CYCLES(T_PRC),
      .SWRESET_DELAY(T_SW), .SLPOUT_DELAY(T_SLP),
      .WIDTH(T_W), .HEIGHT(T_H), .FILL_COLOR(T_FILL)
   ) dut (
      .SYSTEM_CLK(clk), .SYS_RST(rst), .CS(cs), .MOSI(mosi),
      .DC(dc), .LCD_CLK(sclk), .RESET(lcd_rst)
   );

   // Default-parameter instance without a reset driver
   assign rst_d = 1'b0;
   st7735 dut_def (
      .SYSTEM_CLK(clk), .SYS_RST(rst_d), .CS(cs_d), .MOSI(mosi_d),
      .DC(dc_d), .LCD_CLK(sclk_d), .RESET(lcd_rst_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic add(input logic d, input logic [7:0] b);
      tbl[n_tbl].dc   = d;
      tbl[n_tbl].data = b;
      tbl[n_tbl].gap  = -1;
      n_tbl++;
   endtask

   // Expected byte list and inter-byte CS-high gaps, straight from the command list
   task automatic build_table();
      logic [15:0] fill;
      fill  = T_FILL;
      n_tbl = 0;
      add(1'b0, 8'h01); add(1'b0, 8'h11);
      add(1'b0, 8'h3A); add(1'b1, 8'h05);
      add(1'b0, 8'h36); add(1'b1, 8'h00);
      add(1'b0, 8'h2A); repeat (3) add(1'b1, 8'h00); add(1'b1, 8'(T_W - 1));
      add(1'b0, 8'h2B); repeat (3) add(1'b1, 8'h00); add(1'b1, 8'(T_H - 1));
      add(1'b0, 8'h29); add(1'b0, 8'h2C);
      for (int p = 0; p < int'(T_W * T_H); p++) begin
         add(1'b1, fill[15:8]);
         add(1'b1, fill[7:0]);
      end
      for (int i = 1; i < NBYTES; i++) begin
         if (tbl[i-1].dc == 1'b0 && tbl[i-1].data == 8'h01)      tbl[i].gap = 1 + int'(T_SW);
         else if (tbl[i-1].dc == 1'b0 && tbl[i-1].data == 8'h11) tbl[i].gap = 1 + int'(T_SLP);
         else                                                    tbl[i].gap = 1;
      end
   endtask

   // SPI decoder: samples on the falling system edge, captures MOSI on LCD_CLK rises
   always @(negedge clk) begin
      if (rst) begin
         bits     = 0;
         prev_cs  = 1'b1;
         prev_sck = 1'b0;
         gap_cnt  = 0;
      end else begin
         if (cs === 1'b0) begin
            if (prev_cs === 1'b1) begin
               bits     = 0;
               frame_dc = dc;
               gap_q.push_back(gap_cnt);
            end else if (dc !== frame_dc) begin
               dc_bad++;
            end
            if (sclk === 1'b1 && prev_sck === 1'b0) begin
               shift = {shift[6:0], mosi};
               bits++;
            end
         end else begin
            if (prev_cs === 1'b0) begin
               if (bits != 8) frame_bad++;
               rx_q.push_back({frame_dc, shift});
               gap_cnt = 1;
            end else begin
               gap_cnt++;
            end
         end
         prev_cs  = cs;
         prev_sck = sclk;
      end
   end

   // Release reset (held on entry) and check one complete init+fill run
   task automatic run_frame();
      int reset_bad;
      int first_cs;
      int idle_bad;
      int n;
      reset_bad = 0;
      first_cs  = -1;
      idle_bad  = 0;
      rx_q.delete();
      gap_q.delete();
      frame_bad = 0;
      dc_bad    = 0;
      rst = 1'b0;
      for (int k = 1; k <= 3000; k++) begin
         tick();
         if (k <= 8 && lcd_rst !== ((k <= int'(T_RLC)) ? 1'b0 : 1'b1)) reset_bad++;
         if (first_cs < 0 && cs === 1'b0) first_cs = k;
         if (rx_q.size() >= NBYTES) break;
      end
      check("reset_pulse_bad_cycles", 32'(reset_bad), 32'd0);
      check("first_cs_cycle", 32'(first_cs), 32'(FIRST_CS));
      check("byte_count", 32'(rx_q.size()), 32'(NBYTES));
      n = (rx_q.size() < NBYTES) ? rx_q.size() : NBYTES;
      for (int i = 0; i < n; i++) begin
         check($sformatf("byte[%0d] {dc,data}", i), 32'({rx_q[i].dc, rx_q[i].data}),
               32'({tbl[i].dc, tbl[i].data}));
         if (i > 0 && i < gap_q.size())
            check($sformatf("gap_before[%0d]", i), 32'(gap_q[i]), 32'(tbl[i].gap));
      end
      check("frames_not_8_clocks", 32'(frame_bad), 32'd0);
      check("dc_toggle_in_frame", 32'(dc_bad), 32'd0);
      for (int i = 0; i < 200; i++) begin
         tick();
         if (cs !== 1'b1 || sclk !== 1'b0) idle_bad++;
      end
      check("done_idle_bad_cycles", 32'(idle_bad), 32'd0);
   endtask

   // Abort with SYS_RST part-way into byte `target`, then expect a clean restart
   task automatic abort_run(input int target, input int offset, input int hold);
      bit found;
      found = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rx_q.delete();
      for (int k = 0; k < 3000; k++) begin
         tick();
         if (rx_q.size() == target && cs === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      check($sformatf("abort_reached_byte%0d", target), 32'(found), 32'd1);
      repeat (offset) tick();
      rst = 1'b1;
      tick();
      check("abort_cs", 32'(cs), 32'd1);
      check("abort_lcd_clk", 32'(sclk), 32'd0);
      check("abort_reset_pin", 32'(lcd_rst), 32'd1);
      repeat (hold - 1) tick();
      run_frame();
   endtask

   // Default parameters, no reset: panel reset low for 120 cycles, CS never falls
   initial begin
      int bad_r;
      int bad_c;
      bad_r = 0;
      bad_c = 0;
      for (int k = 1; k <= 840; k++) begin
         @(negedge clk);
         if (lcd_rst_d !== ((k <= 120) ? 1'b0 : 1'b1)) bad_r++;
         if (cs_d !== 1'b1) bad_c++;
      end
      check("default_reset_pin_bad_cycles", 32'(bad_r), 32'd0);
      check("default_cs_low_cycles", 32'(bad_c), 32'd0);
      def_done = 1'b1;
   end

   initial begin
      rst   = 1'b1;
      n_cmp = 0;
      n_err = 0;
      frame_bad = 0;
      dc_bad    = 0;
      build_table();

      repeat (3) tick();
      check("rst_cs", 32'(cs), 32'd1);
      check("rst_lcd_clk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_dc", 32'(dc), 32'd0);
      check("rst_reset_pin", 32'(lcd_rst), 32'd1);

      run_frame();

      abort_run(2, 5, 1);
      for (int r = 0; r < 3; r++)
         abort_run(int'($urandom_range(0, NBYTES - 1)), int'($urandom_range(0, 16)),
                   int'($urandom_range(1, 3)));

      wait (def_done);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
